// File: rtl/dbg_ring_link_pkg.sv
// Shared types and constants for the debug ring link buffer.
// Optional statistics are enabled with the macro DBG_RING_LINK_STATS_EN.
package dbg_ring_link_pkg;

    // HOLD waits for a complete packet; STREAM drains a packet longer than the FIFO
    typedef enum logic {
        HOLD   = 1'b0,
        STREAM = 1'b1
    } link_state_t;

    localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/dbg_ring_link_fifo.sv
// One debug ring channel: flit FIFO, stored-packet counter, hold/stream FSM
// and, with DBG_RING_LINK_STATS_EN defined, stall and high-water-mark counters.
module dbg_ring_link_fifo
    import dbg_ring_link_pkg::*;
#(
    parameter int FLIT_WIDTH  = 16,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FLIT_WIDTH-1:0]         in_flit,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [FLIT_WIDTH-1:0]         out_flit,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef DBG_RING_LINK_STATS_EN
    ,
    input  logic                          stat_clr,
    output logic [STAT_WIDTH-1:0]         stat_stall,
    output logic [$clog2(DEPTH+1)-1:0]    stat_hwm
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [FLIT_WIDTH:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    pkt_cnt;
    logic                ready_q;
    link_state_t         state;
    link_state_t         state_next;
    logic                wr_en;
    logic                rd_en;
    logic                wr_last;
    logic                rd_last;

    // in_ready is built from registers only, so out_ready never reaches it
    assign in_ready = ready_q & (count != FULL);
    assign wr_en    = in_valid & in_ready;
    assign rd_en    = out_valid & out_ready;
    assign wr_last  = wr_en & in_last;
    assign rd_last  = rd_en & out_last;

    assign {out_last, out_flit} = mem[rd_ptr];

    // Storage array holds {last, flit}; contents are meaningless after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_last, in_flit};
        end
    end

    // Pointers, occupancy, stored-packet count and the post-reset ready flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (!wr_en && rd_en) begin
                count <= count - 1'b1;
            end
            if (wr_last && !rd_last) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end else if (!wr_last && rd_last) begin
                pkt_cnt <= pkt_cnt - 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Output valid and next state; cut-through mode never leaves HOLD
    always_comb begin
        state_next = state;
        out_valid  = (count != '0);
        if (PACKET_MODE != 0) begin
            case (state)
                HOLD: begin
                    out_valid = (pkt_cnt != '0);
                    if (count == FULL && pkt_cnt == '0) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    out_valid = (count != '0);
                    if (out_ready && count != '0 && out_last) begin
                        state_next = HOLD;
                    end
                end
            endcase
        end
    end

`ifdef DBG_RING_LINK_STATS_EN
    // Saturating stall counter and high-water mark of the registered count
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            stat_stall <= '0;
            stat_hwm   <= '0;
        end else begin
            if (out_valid && !out_ready && stat_stall != {STAT_WIDTH{1'b1}}) begin
                stat_stall <= stat_stall + 1'b1;
            end
            if (count > stat_hwm) begin
                stat_hwm <= count;
            end
        end
    end
`endif

endmodule

// File: rtl/dbg_ring_link_buffer.sv
// Buffered hop for the debug ring: one independent FIFO per channel.
// Optional per-channel statistics ports exist only with DBG_RING_LINK_STATS_EN.
module dbg_ring_link_buffer
    import dbg_ring_link_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int FLIT_WIDTH  = 16,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [CHANNELS*FLIT_WIDTH-1:0]        in_flit,
    input  logic [CHANNELS-1:0]                   in_last,
    input  logic [CHANNELS-1:0]                   in_valid,
    output logic [CHANNELS-1:0]                   in_ready,
    output logic [CHANNELS*FLIT_WIDTH-1:0]        out_flit,
    output logic [CHANNELS-1:0]                   out_last,
    output logic [CHANNELS-1:0]                   out_valid,
    input  logic [CHANNELS-1:0]                   out_ready
`ifdef DBG_RING_LINK_STATS_EN
    ,
    input  logic                                  stat_clr,
    output logic [CHANNELS*STAT_WIDTH-1:0]        stat_stall,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0]   stat_hwm
`endif
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        dbg_ring_link_fifo #(
            .FLIT_WIDTH  (FLIT_WIDTH),
            .DEPTH       (DEPTH),
            .PACKET_MODE (PACKET_MODE)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_flit    (in_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
            .in_last    (in_last[c]),
            .in_valid   (in_valid[c]),
            .in_ready   (in_ready[c]),
            .out_flit   (out_flit[c*FLIT_WIDTH +: FLIT_WIDTH]),
            .out_last   (out_last[c]),
            .out_valid  (out_valid[c]),
            .out_ready  (out_ready[c])
`ifdef DBG_RING_LINK_STATS_EN
            ,
            .stat_clr   (stat_clr),
            .stat_stall (stat_stall[c*STAT_WIDTH +: STAT_WIDTH]),
            .stat_hwm   (stat_hwm[c*$clog2(DEPTH+1) +: $clog2(DEPTH+1)])
`endif
        );
    end

endmodule

// File: tb/tb_dbg_ring_link_buffer.sv
// Bench for dbg_ring_link_buffer: a cut-through instance (dut0) and a
// packet-mode instance (dut1), checked against a queue-based reference model.
// Statistics checks are compiled in with DBG_RING_LINK_STATS_EN.
module tb_dbg_ring_link_buffer;

    localparam int CH    = 2;
    localparam int FW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Per-lane stimulus; lane m = dut*2 + channel
    bit          iv   [4];
    logic [15:0] ifl  [4];
    bit          il   [4];
    bit          ordy [4];

    logic [CH*FW-1:0] in_flit0, out_flit0, in_flit1, out_flit1;
    logic [CH-1:0]    in_last0, in_valid0, in_ready0, out_last0, out_valid0, out_ready0;
    logic [CH-1:0]    in_last1, in_valid1, in_ready1, out_last1, out_valid1, out_ready1;

    assign in_flit0   = {ifl[1], ifl[0]};
    assign in_last0   = {il[1], il[0]};
    assign in_valid0  = {iv[1], iv[0]};
    assign out_ready0 = {ordy[1], ordy[0]};
    assign in_flit1   = {ifl[3], ifl[2]};
    assign in_last1   = {il[3], il[2]};
    assign in_valid1  = {iv[3], iv[2]};
    assign out_ready1 = {ordy[3], ordy[2]};

`ifdef DBG_RING_LINK_STATS_EN
    logic        stat_clr0 = 1'b0;
    logic        stat_clr1 = 1'b0;
    logic [31:0] stat_stall0, stat_stall1;
    logic [5:0]  stat_hwm0, stat_hwm1;
`endif

    dbg_ring_link_buffer #(.CHANNELS(CH), .FLIT_WIDTH(FW), .DEPTH(DEPTH), .PACKET_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_flit(in_flit0), .in_last(in_last0), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_flit(out_flit0), .out_last(out_last0), .out_valid(out_valid0), .out_ready(out_ready0)
`ifdef DBG_RING_LINK_STATS_EN
        , .stat_clr(stat_clr0), .stat_stall(stat_stall0), .stat_hwm(stat_hwm0)
`endif
    );

    dbg_ring_link_buffer #(.CHANNELS(CH), .FLIT_WIDTH(FW), .DEPTH(DEPTH), .PACKET_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_flit(in_flit1), .in_last(in_last1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_flit(out_flit1), .out_last(out_last1), .out_valid(out_valid1), .out_ready(out_ready1)
`ifdef DBG_RING_LINK_STATS_EN
        , .stat_clr(stat_clr1), .stat_stall(stat_stall1), .stat_hwm(stat_hwm1)
`endif
    );

    // Reference model: each lane is a queue of {last, flit}
    logic [16:0] q [4][$];
    bit          streaming [4];
    bit          acc [4];
    bit          rdy_m = 1'b0;
    int          stall_m [4];
    int          hwm_m [4];
    logic [15:0] seen [4][$];

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit          v;
        logic [15:0] f;
        bit          orr;
        bit          exp_rdy;
        bit          exp_ov;
        logic [15:0] exp_f;
    } vec_t;

    vec_t tbl [10];

    function automatic int lasts_stored(int m);
        int n = 0;
        for (int i = 0; i < q[m].size(); i++) begin
            if (q[m][i][16]) n++;
        end
        return n;
    endfunction

    function automatic bit m_in_ready(int m);
        return rdy_m && (q[m].size() != DEPTH);
    endfunction

    // Cut-through shows any stored flit; packet mode shows only complete
    // packets unless an oversize packet is being streamed through
    function automatic bit m_out_valid(int m);
        if (m < 2 || streaming[m]) return q[m].size() != 0;
        return lasts_stored(m) != 0;
    endfunction

    function automatic logic d_in_ready(int m);
        return (m < 2) ? in_ready0[m % 2] : in_ready1[m % 2];
    endfunction

    function automatic logic d_out_valid(int m);
        return (m < 2) ? out_valid0[m % 2] : out_valid1[m % 2];
    endfunction

    function automatic logic d_out_last(int m);
        return (m < 2) ? out_last0[m % 2] : out_last1[m % 2];
    endfunction

    function automatic logic [15:0] d_out_flit(int m);
        return (m < 2) ? out_flit0[(m % 2)*FW +: FW] : out_flit1[(m % 2)*FW +: FW];
    endfunction

    task automatic cmp(string name, int m, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s lane%0d t=%0t: got %0h expected %0h", name, m, $time, act, exp);
        end
    endtask

    task automatic fail_now(string name, int m);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s lane%0d t=%0t: bound expired", name, m, $time);
    endtask

    // Advance the model across the coming edge using the current inputs
    task automatic model_update();
        for (int m = 0; m < 4; m++) begin
            if (!rst_n) begin
                q[m].delete();
                streaming[m] = 1'b0;
                acc[m] = 1'b0;
                stall_m[m] = 0;
                hwm_m[m] = 0;
            end else begin
                bit wr, ov, rd, clr;
                wr = iv[m] && m_in_ready(m);
                ov = m_out_valid(m);
                rd = ov && ordy[m];
                clr = 1'b0;
`ifdef DBG_RING_LINK_STATS_EN
                clr = (m < 2) ? stat_clr0 : stat_clr1;
`endif
                if (clr) begin
                    stall_m[m] = 0;
                    hwm_m[m] = 0;
                end else begin
                    if (ov && !ordy[m] && stall_m[m] < 65535) stall_m[m]++;
                    if (q[m].size() > hwm_m[m]) hwm_m[m] = q[m].size();
                end
                if (m >= 2) begin
                    if (!streaming[m] && q[m].size() == DEPTH && lasts_stored(m) == 0)
                        streaming[m] = 1'b1;
                    else if (streaming[m] && rd && q[m][0][16])
                        streaming[m] = 1'b0;
                end
                if (rd) void'(q[m].pop_front());
                if (wr) q[m].push_back({il[m], ifl[m]});
                acc[m] = wr;
            end
        end
        rdy_m = rst_n;
    endtask

    task automatic checkOutput();
        for (int m = 0; m < 4; m++) begin
            cmp("in_ready", m, 32'(d_in_ready(m)), 32'(m_in_ready(m)));
            cmp("out_valid", m, 32'(d_out_valid(m)), 32'(m_out_valid(m)));
            if (m_out_valid(m)) begin
                cmp("out_flit", m, 32'(d_out_flit(m)), 32'(q[m][0][15:0]));
                cmp("out_last", m, 32'(d_out_last(m)), 32'(q[m][0][16]));
            end
`ifdef DBG_RING_LINK_STATS_EN
            cmp("stat_stall", m, (m < 2) ? 32'(stat_stall0[(m % 2)*16 +: 16]) : 32'(stat_stall1[(m % 2)*16 +: 16]), 32'(stall_m[m]));
            cmp("stat_hwm", m, (m < 2) ? 32'(stat_hwm0[(m % 2)*3 +: 3]) : 32'(stat_hwm1[(m % 2)*3 +: 3]), 32'(hwm_m[m]));
`endif
        end
    endtask

    // One clock: model step, record flits leaving the DUT, then check
    task automatic cycle();
        model_update();
        for (int m = 0; m < 4; m++) begin
            if (rst_n && d_out_valid(m) === 1'b1 && ordy[m]) seen[m].push_back(d_out_flit(m));
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic push_flit(int m, logic [15:0] f, bit l, output int tries);
        iv[m] = 1'b1;
        ifl[m] = f;
        il[m] = l;
        tries = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            tries++;
            if (acc[m]) break;
        end
        if (!acc[m]) fail_now("push_timeout", m);
        iv[m] = 1'b0;
    endtask

    task automatic applyStimulus(vec_t v);
        iv[0] = v.v;
        ifl[0] = v.f;
        il[0] = 1'b0;
        ordy[0] = v.orr;
        cycle();
    endtask

    task automatic check_vector(int i, vec_t v);
        cmp($sformatf("vec%0d_in_ready", i), 0, 32'(in_ready0[0]), 32'(v.exp_rdy));
        cmp($sformatf("vec%0d_out_valid", i), 0, 32'(out_valid0[0]), 32'(v.exp_ov));
        if (v.exp_ov) cmp($sformatf("vec%0d_out_flit", i), 0, 32'(out_flit0[15:0]), 32'(v.exp_f));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t;
        // Cut-through fill past full, one read, refused write retried
        tbl[0] = '{1'b1, 16'h1, 1'b0, 1'b1, 1'b1, 16'h1};
        tbl[1] = '{1'b1, 16'h2, 1'b0, 1'b1, 1'b1, 16'h1};
        tbl[2] = '{1'b1, 16'h3, 1'b0, 1'b1, 1'b1, 16'h1};
        tbl[3] = '{1'b1, 16'h4, 1'b0, 1'b0, 1'b1, 16'h1};
        tbl[4] = '{1'b1, 16'h5, 1'b1, 1'b1, 1'b1, 16'h2};
        tbl[5] = '{1'b1, 16'h5, 1'b0, 1'b0, 1'b1, 16'h2};
        tbl[6] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h3};
        tbl[7] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h4};
        tbl[8] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h5};
        tbl[9] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0};

        for (int m = 0; m < 4; m++) begin
            iv[m] = 1'b0; ifl[m] = '0; il[m] = 1'b0; ordy[m] = 1'b0;
        end

        $display("[TB] reset with valid held on lane 0");
        iv[0] = 1'b1;
        ifl[0] = 16'h00AB;
        rst_n = 1'b0;
        repeat (3) begin
            cycle();
            cmp("rst_in_ready", 0, 32'(in_ready0[0]), 32'd0);
            cmp("rst_out_valid", 0, 32'(out_valid0[0]), 32'd0);
        end
        rst_n = 1'b1;
        cycle();
        cmp("release_in_ready", 0, 32'(in_ready0[0]), 32'd1);
        cmp("release_out_valid", 0, 32'(out_valid0[0]), 32'd0);
        cycle();
        cmp("first_out_valid", 0, 32'(out_valid0[0]), 32'd1);
        cmp("first_out_flit", 0, 32'(out_flit0[15:0]), 32'h00AB);
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (2) cycle();

        $display("[TB] cut-through vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i]);
            check_vector(i, tbl[i]);
        end

        $display("[TB] packet mode 3-flit packet");
        ordy[2] = 1'b1;
        push_flit(2, 16'hA, 1'b0, t);
        cmp("pkt3_wait_a", 2, 32'(out_valid1[0]), 32'd0);
        push_flit(2, 16'hB, 1'b0, t);
        cmp("pkt3_wait_b", 2, 32'(out_valid1[0]), 32'd0);
        push_flit(2, 16'hC, 1'b1, t);
        cmp("pkt3_out_a", 2, 32'({out_valid1[0], out_last1[0], out_flit1[15:0]}), 32'h2000A);
        cycle();
        cmp("pkt3_out_b", 2, 32'({out_valid1[0], out_last1[0], out_flit1[15:0]}), 32'h2000B);
        cycle();
        cmp("pkt3_out_c", 2, 32'({out_valid1[0], out_last1[0], out_flit1[15:0]}), 32'h3000C);
        cycle();
        cmp("pkt3_empty", 2, 32'(out_valid1[0]), 32'd0);

        $display("[TB] packet mode oversize packet");
        seen[2].delete();
        for (int i = 1; i <= 6; i++) push_flit(2, 16'(i), (i == 6), t);
        for (int k = 0; k < 12 && seen[2].size() < 6; k++) cycle();
        cmp("long_count", 2, 32'(seen[2].size()), 32'd6);
        for (int i = 0; i < 6; i++)
            cmp($sformatf("long_flit%0d", i), 2, (seen[2].size() > i) ? 32'(seen[2][i]) : 32'hFFFF_FFFF, 32'(i + 1));
        push_flit(2, 16'h70, 1'b0, t);
        cmp("hold_after_stream", 2, 32'(out_valid1[0]), 32'd0);
        cycle();
        cmp("hold_still", 2, 32'(out_valid1[0]), 32'd0);
        push_flit(2, 16'h71, 1'b1, t);
        cmp("hold_release", 2, 32'({out_valid1[0], out_flit1[15:0]}), 32'h10070);
        repeat (4) cycle();

        $display("[TB] lane 0 stalled while lane 1 streams");
        ordy[0] = 1'b0;
        ordy[1] = 1'b1;
        seen[1].delete();
`ifdef DBG_RING_LINK_STATS_EN
        stat_clr0 = 1'b1;
        cycle();
        stat_clr0 = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            cmp($sformatf("stream_ready%0d", i), 1, 32'(in_ready0[1]), 32'd1);
            iv[1] = 1'b1;
            ifl[1] = 16'h100 + 16'(i);
            iv[0] = (i < 4);
            ifl[0] = 16'h200 + 16'(i);
            cycle();
        end
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        cmp("stream_inflight", 1, 32'(seen[1].size()), 32'd7);
        cycle();
        cmp("stream_done", 1, 32'(seen[1].size()), 32'd8);
        for (int i = 0; i < 8; i++)
            cmp($sformatf("stream_flit%0d", i), 1, (seen[1].size() > i) ? 32'(seen[1][i]) : 32'hFFFF_FFFF, 32'h100 + 32'(i));
`ifdef DBG_RING_LINK_STATS_EN
        cmp("stall_count", 0, 32'(stat_stall0[15:0]), 32'd8);
        cmp("hwm_full", 0, 32'(stat_hwm0[2:0]), 32'd4);
        stat_clr0 = 1'b1;
        cycle();
        stat_clr0 = 1'b0;
        cmp("clr_stall", 0, 32'(stat_stall0[15:0]), 32'd0);
        cmp("clr_hwm", 0, 32'(stat_hwm0[2:0]), 32'd0);
`endif

        $display("[TB] reset pulse with two flits buffered");
        ordy[0] = 1'b1;
        repeat (2) cycle();
        ordy[0] = 1'b0;
        seen[0].delete();
        rst_n = 1'b0;
        cycle();
        cmp("pulse_out_valid", 0, 32'(out_valid0[0]), 32'd0);
        cmp("pulse_in_ready", 0, 32'(in_ready0[0]), 32'd0);
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        repeat (3) begin
            cycle();
            cmp("pulse_no_emit", 0, 32'(out_valid0[0]), 32'd0);
        end
        cmp("pulse_discarded", 0, 32'(seen[0].size()), 32'd0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(99) != 0);
`ifdef DBG_RING_LINK_STATS_EN
            stat_clr0 = ($urandom_range(29) == 0);
            stat_clr1 = ($urandom_range(29) == 0);
`endif
            for (int m = 0; m < 4; m++) begin
                if (!(iv[m] && !acc[m])) begin
                    iv[m] = ($urandom_range(2) != 0);
                    ifl[m] = 16'($urandom);
                    il[m] = ($urandom_range(5) == 0);
                end
                ordy[m] = ($urandom_range(3) != 0);
            end
            cycle();
        end
        rst_n = 1'b1;
`ifdef DBG_RING_LINK_STATS_EN
        stat_clr0 = 1'b0;
        stat_clr1 = 1'b0;
`endif
        for (int m = 0; m < 4; m++) begin
            iv[m] = 1'b0;
            ordy[m] = 1'b1;
        end
        repeat (10) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
